// File: rtl/sbox_ti_sched_pkg.sv
// sbox_ti_sched_pkg
// Shared definitions for the 2-share S-box scheduler. The AES core controller
// and the S-box datapath reuse these definitions so that every block agrees on
// the state-byte count and the index width.
//   SBOX_NBYTES    : state bytes per SubBytes pass
//   SBOX_IDX_W     : width of a state-byte index
//   sched_state_t  : scheduler FSM states
// Optional build macro: SBOX_TI_SCHED_REFRESH_EN adds the REFRESH state.
package sbox_ti_sched_pkg;

  localparam int SBOX_NBYTES = 16;
  localparam int SBOX_IDX_W  = $clog2(SBOX_NBYTES);

  typedef enum logic [2:0] {
    ST_IDLE,
`ifdef SBOX_TI_SCHED_REFRESH_EN
    ST_REFRESH,
`endif
    ST_RUN,
    ST_DRAIN,
    ST_DONE
  } sched_state_t;

endpackage

// File: rtl/sbox_ti_tagpipe.sv
// sbox_ti_tagpipe
// LAT-deep valid-tag shift register that runs in lock-step with the S-box
// pipeline. A tag enters with each issued byte and reaches the last stage
// exactly when that byte's output shares are ready for write-back.
// Ports:
//   clk  in  : clock, rising edge
//   rst  in  : synchronous active-high reset, clears every tag
//   en   in  : shift enable (the pipeline advance strobe)
//   din  in  : tag for the byte entering the pipeline
//   dout out : tag of the byte leaving the last stage
module sbox_ti_tagpipe #(
  parameter int LAT = 3
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic din,
  output logic dout
);

  logic [LAT-1:0] tag;

  // Shift-and-insert form stays legal for LAT=1, where a concatenation slice
  // would need a negative bound.
  always_ff @(posedge clk) begin
    if (rst) begin
      tag <= '0;
    end else if (en) begin
      tag <= (tag << 1) | LAT'(din);
    end
  end

  assign dout = tag[LAT-1];

endmodule

// File: rtl/sbox_ti_sched.sv
// sbox_ti_sched
// Issue/retire scheduler for a pipelined 2-share threshold-implementation
// S-box. The pipeline only advances when a fresh-mask word is available, so
// every stage, counter and valid tag stalls together while rnd_vld is low.
// Ports:
//   clk      in  : clock, rising edge
//   rst      in  : synchronous active-high reset (outputs forced to 0 while high)
//   start    in  : request one SubBytes pass (honoured only when idle)
//   rnd_vld  in  : fresh-mask word available this cycle
//   ref_we   out : re-mask write strobe for byte iss_idx (REFRESH build only)
//   rnd_ack  out : fresh-mask word consumed this cycle
//   sb_en    out : advance the whole S-box pipeline by one stage
//   iss_vld  out : byte iss_idx enters the pipeline this cycle
//   iss_idx  out : state-byte select for the S-box input mux
//   wb_en    out : write S-box output shares back to the state register
//   wb_idx   out : write-back byte index
//   busy     out : a pass is in progress
//   done     out : one-cycle pulse after the last write-back
// Optional build macro: SBOX_TI_SCHED_REFRESH_EN inserts a REFRESH state
// between IDLE and RUN that re-masks every byte before the pass starts.
module sbox_ti_sched
  import sbox_ti_sched_pkg::*;
#(
  parameter int  LAT    = 3,
  parameter int  NBYTES = SBOX_NBYTES,
  localparam int IW     = (NBYTES > 1) ? $clog2(NBYTES) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          rnd_vld,
`ifdef SBOX_TI_SCHED_REFRESH_EN
  output logic          ref_we,
`endif
  output logic          rnd_ack,
  output logic          sb_en,
  output logic          iss_vld,
  output logic [IW-1:0] iss_idx,
  output logic          wb_en,
  output logic [IW-1:0] wb_idx,
  output logic          busy,
  output logic          done
);

  localparam logic [IW-1:0] LAST = IW'(NBYTES - 1);

  sched_state_t  state, state_nxt;
  logic [IW-1:0] iss_cnt, wb_cnt;
  logic          adv, ack, issue, retire, tag_last;
`ifdef SBOX_TI_SCHED_REFRESH_EN
  logic          refw;
`endif

  // Next-state and strobe decode. The pipeline advance (adv) is only possible
  // in RUN and DRAIN; REFRESH consumes randomness without moving the S-box.
  always_comb begin
    state_nxt = state;
    adv       = 1'b0;
    ack       = 1'b0;
    issue     = 1'b0;
`ifdef SBOX_TI_SCHED_REFRESH_EN
    refw      = 1'b0;
`endif
    case (state)
      ST_IDLE: begin
        if (start) begin
`ifdef SBOX_TI_SCHED_REFRESH_EN
          state_nxt = ST_REFRESH;
`else
          state_nxt = ST_RUN;
`endif
        end
      end
`ifdef SBOX_TI_SCHED_REFRESH_EN
      ST_REFRESH: begin
        refw = rnd_vld;
        ack  = rnd_vld;
        if (rnd_vld && iss_cnt == LAST) state_nxt = ST_RUN;
      end
`endif
      ST_RUN: begin
        adv   = rnd_vld;
        ack   = rnd_vld;
        issue = rnd_vld;
        if (rnd_vld && iss_cnt == LAST) state_nxt = ST_DRAIN;
      end
      ST_DRAIN: begin
        adv = rnd_vld;
        ack = rnd_vld;
        if (rnd_vld && tag_last && wb_cnt == LAST) state_nxt = ST_DONE;
      end
      ST_DONE: begin
        state_nxt = ST_IDLE;
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  assign retire = adv & tag_last;

  // State register and byte counters. Counters are parked at 0 in IDLE and
  // DONE so every pass begins from byte 0. The RUN-issue and retire counters
  // stop on the last byte rather than wrapping, so the indices seen during
  // DRAIN/DONE still name the final byte. The REFRESH walk wraps to 0 so RUN
  // starts issuing at byte 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ST_IDLE;
      iss_cnt <= '0;
      wb_cnt  <= '0;
    end else begin
      state <= state_nxt;
      if (state == ST_IDLE || state == ST_DONE) begin
        iss_cnt <= '0;
        wb_cnt  <= '0;
      end else begin
        if (issue && iss_cnt != LAST) iss_cnt <= iss_cnt + IW'(1);
`ifdef SBOX_TI_SCHED_REFRESH_EN
        if (refw) iss_cnt <= (iss_cnt == LAST) ? '0 : iss_cnt + IW'(1);
`endif
        if (retire && wb_cnt != LAST) wb_cnt <= wb_cnt + IW'(1);
      end
    end
  end

  sbox_ti_tagpipe #(
    .LAT (LAT)
  ) u_tagpipe (
    .clk  (clk),
    .rst  (rst),
    .en   (adv),
    .din  (issue),
    .dout (tag_last)
  );

  // Outputs are gated by rst so the datapath sees no strobes during the
  // reset cycle itself, even when reset lands in the middle of a pass.
  assign rnd_ack = ack & ~rst;
  assign sb_en   = adv & ~rst;
  assign iss_vld = issue & ~rst;
  assign iss_idx = rst ? '0 : iss_cnt;
  assign wb_en   = retire & ~rst;
  assign wb_idx  = rst ? '0 : wb_cnt;
  assign busy    = (state != ST_IDLE) & ~rst;
  assign done    = (state == ST_DONE) & ~rst;
`ifdef SBOX_TI_SCHED_REFRESH_EN
  assign ref_we  = refw & ~rst;
`endif

endmodule

// File: doc/sbox_ti_sched.md
SBOX_TI_SCHED -- requirements
Module: sbox_ti_sched

Interface
REQ-001 Parameter LAT, default 3: fixed latency in cycles of the pipelined 2-share S-box datapath, including the SqSc stage; legal range 1..8.
REQ-002 Parameter NBYTES, default 16: number of state bytes per SubBytes pass.
REQ-003 CLK  in  1  single clock; every register updates on its rising edge.
REQ-004 RST  in  1  synchronous, active-high reset.
REQ-005 start  in  1  request one SubBytes pass.
REQ-006 rnd_vld  in  1  fresh-mask word available this cycle.
REQ-007 rnd_ack  out  1  fresh-mask word consumed this cycle.
REQ-008 sb_en  out  1  advance the whole S-box pipeline by one stage.
REQ-009 iss_vld  out  1  byte at iss_idx enters the pipeline this cycle.
REQ-010 iss_idx  out  clog2(NBYTES)  state-byte select for the S-box input mux.
REQ-011 wb_en  out  1  write the S-box output shares back to the state register.
REQ-012 wb_idx  out  clog2(NBYTES)  write-back byte index.
REQ-013 busy  out  1  a pass is in progress.
REQ-014 done  out  1  one-cycle pulse when the last byte has been written back.

Function
REQ-015 States: IDLE, RUN (issuing), DRAIN (no issue, pipeline emptying), DONE (one cycle).
REQ-016 IDLE -> RUN on start=1; start is ignored in every state other than IDLE.
REQ-017 The pipeline advances only when randomness is present: sb_en = rnd_ack = rnd_vld & (state==RUN | state==DRAIN); when rnd_vld=0, all stages, counters and the valid tags hold.
REQ-018 In RUN, each advancing cycle asserts iss_vld with iss_idx = issue counter, then increments the counter; after byte NBYTES-1 is issued, the FSM moves to DRAIN.
REQ-019 The block tracks a LAT-deep valid-tag shift register that shifts only when sb_en=1; wb_en = sb_en & tag[LAT-1], and wb_idx = retire counter, which increments on each wb_en.
REQ-020 DRAIN -> DONE in the cycle after the write-back of byte NBYTES-1; DONE -> IDLE unconditionally.
REQ-021 With no stalls, the first wb_en occurs LAT cycles after the first iss_vld, and done is asserted NBYTES+LAT+1 cycles after start is sampled.
REQ-022 busy = 1 in RUN, DRAIN and DONE; busy = 0 in IDLE.
REQ-023 iss_idx and wb_idx never wrap within a pass; both return to 0 on entry to RUN.
REQ-024 If start=1 in the DONE cycle, it is ignored; a new pass requires start while in IDLE.

Reset
REQ-025 RST=1 forces the IDLE state, clears the counters and valid tags to 0, and holds every output at 0, including in the middle of a pass; the in-flight bytes are discarded.

Configuration
REQ-026 Macro SBOX_TI_SCHED_REFRESH_EN defined: an added state REFRESH sits between IDLE and RUN, and an added output ref_we (1 bit) is defined.
REQ-027 In REFRESH, ref_we = rnd_ack = rnd_vld, and iss_idx steps through 0..NBYTES-1 on each ref_we; this re-masks every byte before the pass.
REQ-028 In REFRESH, done latency increases by NBYTES plus the number of stall cycles.
REQ-029 Macro SBOX_TI_SCHED_REFRESH_EN undefined: neither the REFRESH state nor the ref_we port exists, and the block behaves exactly as REQ-015..REQ-024.

Structure
REQ-030 A shared package holds the FSM state enum, NBYTES, and the index width constant, so that the datapath and the AES core controller reuse them.
REQ-031 The LAT-deep valid-tag pipeline with an enable is one sub-module, sbox_ti_tagpipe.
REQ-032 The sub-module of REQ-031 is the only sub-module; the S-box datapath itself is outside this block.

Verification
REQ-033 LAT=3, rnd_vld=1 constant, start pulse -> iss_vld is high for 16 cycles with iss_idx 0..15, and wb_en is high for 16 cycles with wb_idx 0..15 starting 3 cycles later; done=1 at cycle 20 after start.
REQ-034 Randomness stall: rnd_vld=0 for cycles 5..7 -> sb_en, iss_vld and wb_en are 0 for those 3 cycles, no index is skipped or repeated, and done is delayed by exactly 3 cycles.
REQ-035 start=1 held in RUN, DRAIN and DONE -> exactly one pass runs; a new start in IDLE begins the second pass with iss_idx=0.
REQ-036 RST=1 in the cycle after byte 9 issues -> next cycle busy=0 and all outputs are 0; a later start runs a full, correct 16-byte pass.
REQ-037 LAT=1 and LAT=8 sweeps -> the count of wb_en equals 16 per pass, and done occurs at NBYTES+LAT+1.
REQ-038 SBOX_TI_SCHED_REFRESH_EN defined, rnd_vld=1 -> ref_we is high for 16 cycles with iss_idx 0..15, then RUN starts, and done occurs at cycle 36.
